// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, taken-branch flushes and
// load-use bubbles into hold/flush/bubble strobes, and counts stall and flush cycles.

module phc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_memRead,
  input  logic             de_regWrite,
  input  logic [2:0]       de_writeAdd,
  input  logic [2:0]       fd_src1,
  input  logic [2:0]       fd_src2,
  input  logic             fd_useSrc1,
  input  logic             fd_useSrc2,
  input  logic             ex_branchTaken,
  input  logic             mem_stallReq,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             de_hold,
  output logic             em_hold,
  output logic             de_bubble,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_CNT = 2;

  typedef enum logic [1:0] {S_RUN, S_LU, S_FLUSH, S_MWAIT} state_t;

  state_t r_state, w_state_nxt;
  logic   r_pend, w_pend_nxt;

  logic w_lu_hit;
  logic w_use_run, w_lu_en;
  logic w_act_hold, w_act_brflush, w_act_fdflush, w_act_bubble;

  assign w_lu_hit = de_memRead & de_regWrite &
                    ((fd_useSrc1 & (fd_src1 == de_writeAdd)) |
                     (fd_useSrc2 & (fd_src2 == de_writeAdd)));

  // Each state either applies the common RUN priority chain (optionally without
  // load-use detection) or issues the single trailing F/D flush of a branch.
  always_comb begin
    w_use_run     = 1'b0;
    w_lu_en       = 1'b0;
    w_act_hold    = 1'b0;
    w_act_brflush = 1'b0;
    w_act_fdflush = 1'b0;
    w_act_bubble  = 1'b0;
    w_state_nxt   = S_RUN;
    w_pend_nxt    = r_pend;

    case (r_state)
      S_RUN: begin
        w_use_run = 1'b1;
        w_lu_en   = 1'b1;
      end
      S_LU: begin
        w_use_run = 1'b1;
      end
      S_FLUSH: begin
        if (mem_stallReq) begin
          w_act_hold  = 1'b1;
          w_pend_nxt  = 1'b1;
          w_state_nxt = S_MWAIT;
        end else begin
          w_act_fdflush = 1'b1;
        end
      end
      S_MWAIT: begin
        if (!mem_stallReq && r_pend) begin
          w_act_fdflush = 1'b1;
          w_pend_nxt    = 1'b0;
        end else begin
          w_use_run = 1'b1;
          w_lu_en   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (w_use_run) begin
      if (mem_stallReq) begin
        w_act_hold  = 1'b1;
        w_state_nxt = S_MWAIT;
      end else if (ex_branchTaken) begin
        w_act_brflush = 1'b1;
        w_state_nxt   = S_FLUSH;
      end else if (w_lu_en && w_lu_hit) begin
        w_act_bubble = 1'b1;
        w_state_nxt  = S_LU;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Strobes are gated by rst_n so nothing leaks out while reset is low.
  assign pc_hold   = rst_n & (w_act_hold | w_act_bubble);
  assign fd_hold   = rst_n & (w_act_hold | w_act_bubble);
  assign de_hold   = rst_n & w_act_hold;
  assign em_hold   = rst_n & w_act_hold;
  assign de_bubble = rst_n & w_act_bubble;
  assign fd_flush  = rst_n & (w_act_brflush | w_act_fdflush);
  assign de_flush  = rst_n & w_act_brflush;

  logic [NUM_CNT-1:0]            w_cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] w_cnt;

  assign w_cnt_inc = {de_flush, pc_hold};

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_cnt
      phc_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (cnt_clr),
        .i_inc (w_cnt_inc[g]),
        .o_cnt (w_cnt[g])
      );
    end
  endgenerate

  assign stall_cnt = w_cnt[0];
  assign flush_cnt = w_cnt[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a behavioural
// model that tracks "owed F/D flush" and "just bubbled" flags plus counts.

module tb_pipeline_hazard_ctrl;
  logic        clk, rst_n;
  logic        de_memRead, de_regWrite;
  logic [2:0]  de_writeAdd, fd_src1, fd_src2;
  logic        fd_useSrc1, fd_useSrc2, ex_branchTaken, mem_stallReq, cnt_clr;
  logic        pc_hold, fd_hold, de_hold, em_hold, de_bubble, fd_flush, de_flush;
  logic [15:0] stall_cnt, flush_cnt;

  int n_err = 0;
  int n_chk = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .de_memRead(de_memRead), .de_regWrite(de_regWrite),
    .de_writeAdd(de_writeAdd), .fd_src1(fd_src1), .fd_src2(fd_src2),
    .fd_useSrc1(fd_useSrc1), .fd_useSrc2(fd_useSrc2), .ex_branchTaken(ex_branchTaken),
    .mem_stallReq(mem_stallReq), .cnt_clr(cnt_clr), .pc_hold(pc_hold), .fd_hold(fd_hold),
    .de_hold(de_hold), .em_hold(em_hold), .de_bubble(de_bubble), .fd_flush(fd_flush),
    .de_flush(de_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a taken branch owes one more F/D flush; a bubble blocks the next load-use.
  bit m_owed, m_block, n_owed, n_block;
  int m_stall, m_flush;
  logic [6:0] e_haz;  // {pc,fd,de,em hold, de_bubble, fd_flush, de_flush}

  wire [6:0] w_haz = {pc_hold, fd_hold, de_hold, em_hold, de_bubble, fd_flush, de_flush};

  task automatic model_reset();
    m_owed = 0; m_block = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval();
    bit hit;
    hit = de_memRead && de_regWrite &&
          ((fd_useSrc1 && fd_src1 == de_writeAdd) || (fd_useSrc2 && fd_src2 == de_writeAdd));
    e_haz = '0; n_owed = m_owed; n_block = 0;
    if (!rst_n) model_reset();
    else if (mem_stallReq) e_haz = 7'b1111000;
    else if (m_owed) begin e_haz = 7'b0000010; n_owed = 0; end
    else if (ex_branchTaken) begin e_haz = 7'b0000011; n_owed = 1; end
    else if (hit && !m_block) begin e_haz = 7'b1100100; n_block = 1; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_owed = n_owed; m_block = n_block;
      if (cnt_clr) begin m_stall = 0; m_flush = 0; end
      else begin
        if (e_haz[6] && m_stall < 65535) m_stall++;
        if (e_haz[0] && m_flush < 65535) m_flush++;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    de_memRead = 0; de_regWrite = 0; de_writeAdd = 0; fd_src1 = 0; fd_src2 = 0;
    fd_useSrc1 = 0; fd_useSrc2 = 0; ex_branchTaken = 0; mem_stallReq = 0; cnt_clr = 0;
  endtask

  task automatic set_lu();
    de_memRead = 1; de_regWrite = 1; de_writeAdd = 3'd3; fd_src2 = 3'd3; fd_useSrc2 = 1;
    fd_src1 = 3'd5; fd_useSrc1 = 1;
  endtask

  // Drains any owed flush, then zeroes both counters.
  task automatic idle_clear();
    set_idle(); model_eval(); tick();
    model_eval(); tick();
    cnt_clr = 1; model_eval(); tick();
    cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; set_lu(); ex_branchTaken = 1; mem_stallReq = 1; cnt_clr = 0;
    model_reset();
    #7;
    n_chk++;
    if (w_haz !== 7'b0) begin n_err++; $display("FAIL reset_outputs: got %b want 0000000", w_haz); end
    n_chk++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1; set_idle(); set_lu();
    model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b1100100) begin n_err++; $display("FAIL reset_first_run: got %b want 1100100", w_haz); end
    tick();
  endtask

  task automatic test_load_use();
    idle_clear();
    set_lu(); model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b1100100) begin n_err++; $display("FAIL lu_cycle0: got %b want 1100100", w_haz); end
    tick(); model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b0) begin n_err++; $display("FAIL lu_cycle1: got %b want 0000000", w_haz); end
    tick();
    n_chk++;
    if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_branch();
    idle_clear();
    ex_branchTaken = 1; model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b0000011) begin n_err++; $display("FAIL br_cycle0: got %b want 0000011", w_haz); end
    tick(); model_eval(); #2;  // branch still high: ignored behind the bubble
    n_chk++;
    if (w_haz !== 7'b0000010) begin n_err++; $display("FAIL br_cycle1: got %b want 0000010", w_haz); end
    tick();
    n_chk++;
    if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
    ex_branchTaken = 0;
  endtask

  task automatic test_branch_lu();
    idle_clear();
    set_lu(); ex_branchTaken = 1; model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b0000011) begin n_err++; $display("FAIL brlu_cycle0: got %b want 0000011", w_haz); end
    tick(); ex_branchTaken = 0; model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b0000010) begin n_err++; $display("FAIL brlu_flush_state: got %b want 0000010", w_haz); end
    tick(); model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b1100100) begin n_err++; $display("FAIL brlu_then_lu: got %b want 1100100", w_haz); end
    tick();
  endtask

  task automatic test_stall_flush();
    idle_clear();
    ex_branchTaken = 1; model_eval(); tick();
    ex_branchTaken = 0; mem_stallReq = 1;
    for (int i = 0; i < 3; i++) begin
      model_eval(); #2;
      n_chk++;
      if (w_haz !== 7'b1111000) begin n_err++; $display("FAIL sf_hold%0d: got %b want 1111000", i, w_haz); end
      tick();
    end
    mem_stallReq = 0; model_eval(); #2;
    n_chk++;
    if (w_haz !== 7'b0000010) begin n_err++; $display("FAIL sf_pend_flush: got %b want 0000010", w_haz); end
    tick();
    n_chk++;
    if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1) begin
      n_err++; $display("FAIL sf_counts: got %0d/%0d want 3/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    idle_clear();
    mem_stallReq = 1;
    repeat (65540) begin model_eval(); tick(); end
    n_chk++;
    if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    cnt_clr = 1; model_eval(); #2;
    n_chk++;
    if (pc_hold !== 1'b1) begin n_err++; $display("FAIL sat_pc_hold: got %b want 1", pc_hold); end
    tick();
    n_chk++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL sat_clear: got %h want 0000", stall_cnt); end
    set_idle(); model_eval(); tick();
  endtask

  task automatic test_reset_mid();
    idle_clear();
    ex_branchTaken = 1; model_eval(); tick();
    ex_branchTaken = 0; mem_stallReq = 1; model_eval(); tick();
    model_eval(); tick();
    rst_n = 0; set_lu(); ex_branchTaken = 1; model_eval(); #1;
    n_chk++;
    if (w_haz !== 7'b0) begin n_err++; $display("FAIL rmid_outputs: got %b want 0000000", w_haz); end
    n_chk++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL rmid_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    tick();
    rst_n = 1; set_idle();
    for (int i = 0; i < 3; i++) begin
      model_eval(); #2;
      n_chk++;
      if (fd_flush !== 1'b0) begin n_err++; $display("FAIL rmid_no_flush%0d: got %b want 0", i, fd_flush); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      mem_stallReq   = ($urandom_range(0, 9) < 2);
      ex_branchTaken = ($urandom_range(0, 9) < 2);
      de_memRead     = ($urandom_range(0, 3) != 0);
      de_regWrite    = ($urandom_range(0, 3) != 0);
      de_writeAdd    = 3'($urandom_range(0, 3));
      fd_src1        = 3'($urandom_range(0, 3));
      fd_src2        = 3'($urandom_range(0, 3));
      fd_useSrc1     = 1'($urandom_range(0, 1));
      fd_useSrc2     = 1'($urandom_range(0, 1));
      cnt_clr        = ($urandom_range(0, 49) == 0);
      model_eval(); #2;
      n_chk++;
      if (w_haz !== e_haz) begin n_err++; $display("FAIL rnd_haz c=%0d: got %b want %b", c, w_haz, e_haz); end
      n_chk++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
        n_err++; $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
    end
    rst_n = 1; set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_branch_lu();
    test_stall_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly these ports; all non-clock inputs SHALL be sampled on posedge clk:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- de_memRead  in  1  instruction in Execute is a load (from the D/E buffer control field).
- de_regWrite  in  1  instruction in Execute writes a register.
- de_writeAdd  in  3  destination register of the instruction in Execute.
- fd_src1, fd_src2  in  3 each  source registers of the instruction in Decode.
- fd_useSrc1, fd_useSrc2  in  1 each  the Decode instruction reads the matching source.
- ex_branchTaken  in  1  a branch resolved taken in Execute this cycle.
- mem_stallReq  in  1  Memory stage busy; held high until done.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_hold, fd_hold  out  1 each  freeze PC and the F/D buffer.
- de_hold, em_hold  out  1 each  freeze the D/E and E/M buffers.
- de_bubble  out  1  load all-zero control signals into the D/E buffer.
- fd_flush, de_flush  out  1 each  zero the F/D and D/E buffer contents.
- stall_cnt, flush_cnt  out  16 each  performance counters.
REQ-002 Clock is clk; reset is rst_n, asynchronous and active-low.

Function
REQ-003 The FSM SHALL have states RUN, LU, FLUSH and MWAIT, plus a 1-bit pend_flush register.
REQ-004 Hazard outputs SHALL be combinational from the current state and current inputs, and SHALL take effect at the next clock edge.
REQ-005 The load-use hit SHALL be de_memRead & de_regWrite & ((fd_useSrc1 & fd_src1==de_writeAdd) | (fd_useSrc2 & fd_src2==de_writeAdd)).
REQ-006 Event priority SHALL be mem_stallReq, then ex_branchTaken, then load-use hit.
REQ-007 RUN state behaviour:
- mem_stallReq: pc_hold=fd_hold=de_hold=em_hold=1; next state MWAIT.
- else ex_branchTaken: fd_flush=de_flush=1; next state FLUSH.
- else load-use hit: pc_hold=fd_hold=de_bubble=1; next state LU.
- else all hazard outputs 0; stay in RUN.
REQ-008 LU state SHALL apply the RUN rules with load-use detection disabled; with no event, next state RUN, so each load-use inserts exactly one bubble.
REQ-009 FLUSH state behaviour:
- ex_branchTaken is ignored, because the Execute slot is a bubble.
- With no mem_stallReq: fd_flush=1, next state RUN.
- With mem_stallReq: all four holds=1, pend_flush set, next state MWAIT.
REQ-010 MWAIT state behaviour:
- While mem_stallReq=1: all four holds=1.
- On the first cycle mem_stallReq=0 with pend_flush=1: behave exactly as FLUSH with no mem_stallReq, and clear pend_flush.
- On the first cycle mem_stallReq=0 with pend_flush=0: behave exactly as RUN.
REQ-011 In a given cycle, the holds SHALL never be asserted together with fd_flush or de_flush, and de_bubble SHALL never be asserted together with de_flush.
REQ-012 stall_cnt SHALL increment by 1 in every cycle pc_hold=1, and saturate at 16'hFFFF.
REQ-013 flush_cnt SHALL increment by 1 for each accepted taken branch (a cycle where de_flush=1), and saturate at 16'hFFFF.
REQ-014 cnt_clr=1 SHALL zero both counters at the clock edge, overriding any increment in the same cycle.

Reset
REQ-015 rst_n=0 SHALL immediately set state=RUN, pend_flush=0, stall_cnt=flush_cnt=0.
REQ-016 While rst_n=0, every hazard output SHALL be forced to 0, regardless of inputs.
REQ-017 Reset asserted mid-stall or mid-flush SHALL abandon the operation, with no pending flush surviving reset.
REQ-018 After rst_n deasserts, the first posedge SHALL evaluate as RUN.

Verification
REQ-019 Load-use: de_memRead=1, de_regWrite=1, de_writeAdd=3, fd_src2=3, fd_useSrc2=1, held 2 cycles:
- cycle 0: pc_hold=fd_hold=de_bubble=1.
- cycle 1: all hazard outputs 0.
- stall_cnt=1.
REQ-020 Taken branch in RUN: cycle 0 fd_flush=de_flush=1; cycle 1 fd_flush=1, de_flush=0; flush_cnt=1.
REQ-021 Branch and load-use hit in the same cycle: only fd_flush=de_flush=1; de_bubble=0; next state FLUSH.
REQ-022 Stall during flush: branch, then mem_stallReq high for 3 cycles:
- 3 cycles of all four holds.
- then 1 cycle fd_flush=1.
- stall_cnt=3.
REQ-023 Saturation and clear: preload stall_cnt to 16'hFFFF with sustained mem_stallReq:
- It holds at 16'hFFFF.
- cnt_clr together with pc_hold=1 gives 0.
REQ-024 Reset mid-operation: rst_n pulsed low during MWAIT with pend_flush=1:
- All outputs are 0 immediately.
- After release, no fd_flush occurs.
